// File: rtl/tick_sched.sv
// Multi-channel tick scheduler: shares clk among NCH timers as one-cycle enable pulses.
// Optional TICK_SCHED_SYNC_START_EN: a config commit restarts every channel counter.
module tick_sched #(
    parameter  int NCH = 4,
    parameter  int W   = 28,
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           run,
    input  logic           clr,
    input  logic           cfg_valid,
    output logic           cfg_ready,
    input  logic [CHW-1:0] cfg_ch,
    input  logic [W-1:0]   cfg_period,
    input  logic           cfg_en,
    output logic [NCH-1:0] tick,
    output logic           running
);

    typedef enum logic [1:0] {IDLE, RUN, APPLY} state_t;

    state_t         state;
    state_t         state_nxt;
    logic           accept;
    logic           count_en;
    logic           cap_valid;

    logic [CHW-1:0] cap_ch;
    logic [W-1:0]   cap_period;
    logic           cap_en;

    logic [W-1:0]   period [NCH];
    logic [W-1:0]   cnt    [NCH];
    logic [NCH-1:0] en;

    assign accept    = cfg_valid && cfg_ready;
    assign cap_valid = (int'(cap_ch) < NCH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            running <= 1'b0;
        end else begin
            state   <= state_nxt;
            running <= (state_nxt == RUN);
        end
    end

    // Acceptance wins over the run/pause decision in the same cycle.
    always_comb begin
        state_nxt = state;
        if (accept)
            state_nxt = APPLY;
        else if (run)
            state_nxt = RUN;
        else
            state_nxt = IDLE;
    end

    always_comb begin
        cfg_ready = (state != APPLY);
        count_en  = (state == RUN) && (state_nxt == RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_ch     <= '0;
            cap_period <= '0;
            cap_en     <= 1'b0;
        end else if (accept) begin
            cap_ch     <= cfg_ch;
            cap_period <= cfg_period;
            cap_en     <= cfg_en;
        end
    end

    // Counters only advance on edges that stay in RUN, so leaving RUN drops that edge's tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick <= '0;
            en   <= '0;
            for (int i = 0; i < NCH; i++) begin
                period[i] <= '0;
                cnt[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                tick[i] <= 1'b0;
                if (clr) begin
                    cnt[i] <= '0;
                end else if (state == APPLY) begin
`ifdef TICK_SCHED_SYNC_START_EN
                    if (cap_valid)
                        cnt[i] <= '0;
`else
                    if (cap_valid && int'(cap_ch) == i)
                        cnt[i] <= '0;
`endif
                end else if (count_en && en[i]) begin
                    if (cnt[i] == period[i]) begin
                        cnt[i]  <= '0;
                        tick[i] <= 1'b1;
                    end else begin
                        cnt[i] <= cnt[i] + 1'b1;
                    end
                end
                if (state == APPLY && cap_valid && int'(cap_ch) == i) begin
                    period[i] <= cap_period;
                    en[i]     <= cap_en;
                end
            end
        end
    end

endmodule

// File: tb/tb_tick_sched.sv
// Randomized and directed bench for tick_sched against a behavioural scheduler model.
// Honours TICK_SCHED_SYNC_START_EN in the model when the macro is defined.
module tb_tick_sched;

    localparam int NCH = 5;
    localparam int W   = 6;
    localparam int CHW = 3;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           run;
    logic           clr;
    logic           cfg_valid;
    logic           cfg_ready;
    logic [CHW-1:0] cfg_ch;
    logic [W-1:0]   cfg_period;
    logic           cfg_en;
    logic [NCH-1:0] tick;
    logic           running;

    int tests = 0;
    int fails = 0;

    typedef enum {M_IDLE, M_RUN, M_APPLY} mode_t;
    mode_t          m_mode;
    int             m_period [NCH];
    int             m_cnt    [NCH];
    bit             m_en     [NCH];
    int             c_ch;
    int             c_p;
    bit             c_en;
    logic [NCH-1:0] m_tick;
    logic           m_running;
    logic           m_ready;

    tick_sched #(.NCH(NCH), .W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .clr        (clr),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_ch     (cfg_ch),
        .cfg_period (cfg_period),
        .cfg_en     (cfg_en),
        .tick       (tick),
        .running    (running)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic modelReset();
        m_mode = M_IDLE;
        for (int i = 0; i < NCH; i++) begin
            m_period[i] = 0;
            m_cnt[i]    = 0;
            m_en[i]     = 1'b0;
        end
        c_ch = 0; c_p = 0; c_en = 1'b0;
        m_tick = '0; m_running = 1'b0; m_ready = 1'b1;
    endtask

    // One clock edge of the scheduler as described in plain rules.
    task automatic modelStep();
        bit    acc;
        mode_t nxt;
        acc = cfg_valid && (m_mode != M_APPLY);
        nxt = acc ? M_APPLY : (run ? M_RUN : M_IDLE);
        m_tick = '0;
        if (m_mode == M_APPLY && c_ch < NCH) begin
            m_period[c_ch] = c_p;
            m_en[c_ch]     = c_en;
`ifdef TICK_SCHED_SYNC_START_EN
            for (int i = 0; i < NCH; i++) m_cnt[i] = 0;
`else
            m_cnt[c_ch] = 0;
`endif
        end
        if (m_mode == M_RUN && nxt == M_RUN) begin
            for (int i = 0; i < NCH; i++) begin
                if (m_en[i]) begin
                    if (m_cnt[i] == m_period[i]) begin
                        m_cnt[i]  = 0;
                        m_tick[i] = 1'b1;
                    end else begin
                        m_cnt[i] = m_cnt[i] + 1;
                    end
                end
            end
        end
        if (clr) begin
            for (int i = 0; i < NCH; i++) m_cnt[i] = 0;
            m_tick = '0;
        end
        if (acc) begin
            c_ch = int'(cfg_ch);
            c_p  = int'(cfg_period);
            c_en = cfg_en;
        end
        m_mode    = nxt;
        m_running = (nxt == M_RUN);
        m_ready   = (nxt != M_APPLY);
    endtask

    task automatic checkAll();
        checkOutput("tick",      32'(tick),      32'(m_tick));
        checkOutput("running",   32'(running),   32'(m_running));
        checkOutput("cfg_ready", 32'(cfg_ready), 32'(m_ready));
    endtask

    task automatic applyStimulus(input bit r, input bit c, input bit v, input int ch, input int p, input bit e);
        run        = r;
        clr        = c;
        cfg_valid  = v;
        cfg_ch     = CHW'(ch);
        cfg_period = W'(p);
        cfg_en     = e;
        @(posedge clk);
        modelStep();
        @(negedge clk);
        checkAll();
    endtask

    task automatic runCycles(input int n, input bit r);
        for (int k = 0; k < n; k++) applyStimulus(r, 1'b0, 1'b0, 0, 0, 1'b0);
    endtask

    initial begin
        bit r_rand;
        rst_n = 1'b0; run = 1'b0; clr = 1'b0; cfg_valid = 1'b0;
        cfg_ch = '0; cfg_period = '0; cfg_en = 1'b0;
        modelReset();
        #12;
        checkOutput("reset_tick",      32'(tick),      32'd0);
        checkOutput("reset_running",   32'(running),   32'd0);
        checkOutput("reset_cfg_ready", 32'(cfg_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(1'b0, 1'b0, 1'b1, 0, 3, 1'b1);
        runCycles(14, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1, 1, 0, 1'b1);
        runCycles(6, 1'b1);
        runCycles(5, 1'b0);
        runCycles(6, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1, 2, 9, 1'b1);
        runCycles(7, 1'b1);
        runCycles(3, 1'b0);
        runCycles(12, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1, 1, 5, 1'b1);
        runCycles(9, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1, 1, 2, 1'b1);
        runCycles(10, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1, 3, 4, 1'b1);
        runCycles(8, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1, 5, 1, 1'b1);
        runCycles(4, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1, 7, 1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 0, 7, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1, 4, 63, 1'b1);
        runCycles(70, 1'b1);

        r_rand = 1'b1;
        for (int k = 0; k < 1500; k++) begin
            int p;
            if ($urandom_range(0, 19) == 0) r_rand = ~r_rand;
            p = ($urandom_range(0, 7) == 0) ? 63 : int'($urandom_range(0, 9));
            applyStimulus(r_rand, ($urandom_range(0, 39) == 0), ($urandom_range(0, 5) == 0),
                          int'($urandom_range(0, 7)), p, ($urandom_range(0, 4) != 0));
        end

        applyStimulus(1'b1, 1'b0, 1'b1, 4, 2, 1'b1);
        rst_n = 1'b0;
        #1;
        modelReset();
        checkOutput("apply_reset_tick",      32'(tick),      32'd0);
        checkOutput("apply_reset_running",   32'(running),   32'd0);
        checkOutput("apply_reset_cfg_ready", 32'(cfg_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        runCycles(12, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1, 4, 1, 1'b1);
        runCycles(8, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
